// File: rtl/maxpool_2x2_stream.sv
// ============================================================================
//  Module   : maxpool_2x2_stream
//  Purpose  : Streaming 2x2 / stride-2 max-pooling stage. Pixels arrive in
//             raster order with no backpressure. Each even row leaves one
//             column-pair maximum per window in a line buffer. The matching
//             odd row combines that stored maximum with its own column pair
//             and emits one pooled value per window.
//  Ports    : Clk        - clock, rising edge
//             Rst        - synchronous active-high reset
//             In_Valid   - In_Data/Row_Odd carry a pixel this cycle
//             In_Data    - signed pixel
//             Row_Odd    - 0 = first row of a pool pair, 1 = second row
//             Out_Valid  - one-cycle pulse, Out_Data is a pooled value
//             Out_Data   - signed 2x2 maximum, held while Out_Valid=0
//             Frame_Done - pulses with the last pooled output of a frame
//             Row_Err    - sticky, Row_Odd changed in the middle of a row
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool_2x2_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_WIDTH  = 100,
    parameter int NUM_ROWS   = 100
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         In_Valid,
    input  logic signed [DATA_WIDTH-1:0] In_Data,
    input  logic                         Row_Odd,
    output logic                         Out_Valid,
    output logic signed [DATA_WIDTH-1:0] Out_Data,
    output logic                         Frame_Done,
    output logic                         Row_Err
);

    localparam int c_HALF   = ROW_WIDTH / 2;
    localparam int c_OUTS   = c_HALF * (NUM_ROWS / 2);
    localparam int c_COL_W  = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam int c_ADDR_W = (c_HALF > 1)    ? $clog2(c_HALF)    : 1;
    localparam int c_CNT_W  = (c_OUTS > 1)    ? $clog2(c_OUTS)    : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(ROW_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_OUTS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_COL_W-1:0]           r_col;
    logic signed [DATA_WIDTH-1:0] r_hold;
    logic [c_CNT_W-1:0]           r_out_cnt;
    logic                         r_last_odd;
    logic                         r_out_valid;
    logic signed [DATA_WIDTH-1:0] r_out_data;
    logic                         r_frame_done;
    logic                         r_row_err;
    logic signed [DATA_WIDTH-1:0] r_linebuf [0:c_HALF-1];

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic                         w_col_odd;
    logic                         w_col_zero;
    logic [c_ADDR_W-1:0]          w_addr;
    logic signed [DATA_WIDTH-1:0] w_pair;
    logic signed [DATA_WIDTH-1:0] w_lb_rd;
    logic signed [DATA_WIDTH-1:0] w_pool;
    logic                         w_lb_wr;
    logic                         w_emit;
    logic                         w_last_out;

    always_comb begin
        w_col_odd  = r_col[0];
        w_col_zero = (r_col == '0);
        w_addr     = c_ADDR_W'(r_col >> 1);
        w_pair     = (r_hold > In_Data) ? r_hold : In_Data;
        w_lb_rd    = r_linebuf[w_addr];
        w_pool     = (w_pair > w_lb_rd) ? w_pair : w_lb_rd;
        // The current Row_Odd steers the datapath even if it disagrees with
        // the parity latched at column 0; the mismatch is only reported.
        w_lb_wr    = In_Valid && w_col_odd && !Row_Odd;
        w_emit     = In_Valid && w_col_odd &&  Row_Odd;
        w_last_out = (r_out_cnt == c_CNT_LAST);
    end

    // Line buffer is deliberately left out of reset: an even row rewrites
    // every entry before the following odd row reads any of them.
    always_ff @(posedge Clk) begin
        if (w_lb_wr) begin
            r_linebuf[w_addr] <= w_pair;
        end
    end

    // Column counter and even-column hold register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_col  <= '0;
            r_hold <= '0;
        end else if (In_Valid) begin
            if (!w_col_odd) begin
                r_hold <= In_Data;
            end
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
            end else begin
                r_col <= r_col + c_COL_W'(1);
            end
        end
    end

    // Pooled output, frame counter and end-of-frame pulse
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_frame_done <= 1'b0;
            r_out_cnt    <= '0;
        end else begin
            r_out_valid  <= w_emit;
            r_frame_done <= w_emit && w_last_out;
            if (w_emit) begin
                r_out_data <= w_pool;
                if (w_last_out) begin
                    r_out_cnt <= '0;
                end else begin
                    r_out_cnt <= r_out_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    // Row parity consistency check
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_last_odd <= 1'b0;
            r_row_err  <= 1'b0;
        end else if (In_Valid) begin
            if (w_col_zero) begin
                r_last_odd <= Row_Odd;
            end else if (Row_Odd != r_last_odd) begin
                r_row_err <= 1'b1;
            end
        end
    end

    assign Out_Valid  = r_out_valid;
    assign Out_Data   = r_out_data;
    assign Frame_Done = r_frame_done;
    assign Row_Err    = r_row_err;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_2x2_stream.sv
// ============================================================================
//  Module   : tb_maxpool_2x2_stream
//  Purpose  : Scoreboard bench for maxpool_2x2_stream. Three instances cover
//             4x2, 2x2 and 4x4 frames. A window-level reference model pushes
//             expected events into a queue; a negedge monitor pops and
//             compares them against the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_maxpool_2x2_stream;

    localparam int DW = 16;
    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 vld [ND];
    logic signed [DW-1:0] din [ND];
    logic                 odd [ND];
    logic                 ov  [ND];
    logic signed [DW-1:0] od  [ND];
    logic                 fd  [ND];
    logic                 re  [ND];

    maxpool_2x2_stream #(.DATA_WIDTH(DW), .ROW_WIDTH(4), .NUM_ROWS(2)) u_dut0 (
        .Clk(clk), .Rst(rst), .In_Valid(vld[0]), .In_Data(din[0]), .Row_Odd(odd[0]),
        .Out_Valid(ov[0]), .Out_Data(od[0]), .Frame_Done(fd[0]), .Row_Err(re[0]));

    maxpool_2x2_stream #(.DATA_WIDTH(DW), .ROW_WIDTH(2), .NUM_ROWS(2)) u_dut1 (
        .Clk(clk), .Rst(rst), .In_Valid(vld[1]), .In_Data(din[1]), .Row_Odd(odd[1]),
        .Out_Valid(ov[1]), .Out_Data(od[1]), .Frame_Done(fd[1]), .Row_Err(re[1]));

    maxpool_2x2_stream #(.DATA_WIDTH(DW), .ROW_WIDTH(4), .NUM_ROWS(4)) u_dut2 (
        .Clk(clk), .Rst(rst), .In_Valid(vld[2]), .In_Data(din[2]), .Row_Odd(odd[2]),
        .Out_Valid(ov[2]), .Out_Data(od[2]), .Frame_Done(fd[2]), .Row_Err(re[2]));

    // Expected events: 0 = pooled output, 1 = reset, 2 = Row_Err rises
    typedef struct {
        int                   due;
        int                   id;
        int                   kind;
        logic signed [DW-1:0] data;
        bit                   fdone;
    } exp_t;

    exp_t q[$];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Reference model: window view of the frame
    // ------------------------------------------------------------------
    int                   RW [ND];
    int                   NR [ND];
    int                   m_col [ND];
    int                   m_cnt [ND];
    bit                   m_last [ND];
    bit                   m_err [ND];
    logic signed [DW-1:0] m_row [ND][4];   // pixels of the row in progress
    logic signed [DW-1:0] m_buf [ND][2];   // pair maxima of the last even row

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_px(input int id, input logic signed [DW-1:0] d, input bit o);
        int c;
        exp_t e;
        logic signed [DW-1:0] pm;
        c = m_col[id];
        m_row[id][c] = d;
        if (c == 0) begin
            m_last[id] = o;
        end else if (o != m_last[id] && !m_err[id]) begin
            m_err[id] = 1'b1;
            e = '{cyc + 1, id, 2, '0, 1'b0};
            q.push_back(e);
        end
        if (c % 2 == 1) begin
            pm = smax(m_row[id][c-1], d);
            if (!o) begin
                m_buf[id][c/2] = pm;
            end else begin
                m_cnt[id] = m_cnt[id] + 1;
                e = '{cyc + 1, id, 0, smax(pm, m_buf[id][c/2]), 1'b0};
                if (m_cnt[id] == (RW[id] / 2) * (NR[id] / 2)) begin
                    e.fdone   = 1'b1;
                    m_cnt[id] = 0;
                end
                q.push_back(e);
            end
        end
        m_col[id] = (c + 1) % RW[id];
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input int id, input bit v, input logic signed [DW-1:0] d, input bit o);
        @(posedge clk);
        #1;
        for (int k = 0; k < ND; k++) vld[k] = 1'b0;
        vld[id] = v;
        din[id] = d;
        odd[id] = o;
        if (v) model_px(id, d, o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < ND; k++) begin
                vld[k] = 1'b0;
                din[k] = DW'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < ND; k++) begin
            vld[k]    = 1'b0;
            e         = '{cyc + 1, k, 1, '0, 1'b0};
            q.push_back(e);
            m_col[k]  = 0;
            m_cnt[k]  = 0;
            m_last[k] = 1'b0;
            m_err[k]  = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_row(input int id, input bit o, input int gap, input int px[4]);
        for (int i = 0; i < RW[id]; i++) begin
            drive(id, 1'b1, DW'(px[i]), o);
            if (gap > 0) idle(gap);
        end
    endtask

    task automatic rand_frame(input int id, input int maxgap);
        int px[4];
        for (int r = 0; r < NR[id]; r++) begin
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 5))
                    0:       px[i] = -32768;
                    1:       px[i] = 32767;
                    default: px[i] = $signed(DW'($urandom));
                endcase
            end
            send_row(id, r[0], $urandom_range(0, maxgap), px);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    task automatic chk(input string name, input int id, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, id, cyc, act, exp);
        end
    endtask

    bit                   started = 1'b0;
    logic signed [DW-1:0] held  [ND];
    bit                   e_err [ND];

    always @(negedge clk) begin
        bit   vdue [ND];
        bit   fdue [ND];
        exp_t e;
        for (int k = 0; k < ND; k++) begin
            vdue[k] = 1'b0;
            fdue[k] = 1'b0;
        end
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due < cyc) chk("late_event", e.id, cyc, e.due);
            case (e.kind)
                0: begin
                    vdue[e.id] = 1'b1;
                    fdue[e.id] = e.fdone;
                    held[e.id] = e.data;
                end
                1: begin
                    started     = 1'b1;
                    held[e.id]  = '0;
                    e_err[e.id] = 1'b0;
                end
                default: e_err[e.id] = 1'b1;
            endcase
        end
        if (started) begin
            for (int k = 0; k < ND; k++) begin
                chk("out_valid",  k, int'(ov[k]), int'(vdue[k]));
                chk("out_data",   k, int'(od[k]), int'(held[k]));
                chk("frame_done", k, int'(fd[k]), int'(fdue[k]));
                chk("row_err",    k, int'(re[k]), int'(e_err[k]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        RW  = '{4, 2, 4};
        NR  = '{2, 2, 4};
        for (int k = 0; k < ND; k++) begin
            vld[k]  = 1'b0;
            din[k]  = '0;
            odd[k]  = 1'b0;
            held[k] = '0;
            e_err[k] = 1'b0;
            for (int j = 0; j < 4; j++) m_row[k][j] = '0;
            for (int j = 0; j < 2; j++) m_buf[k][j] = '0;
        end
        do_reset();
        idle(2);

        // Basic 2x2: expect 5 then 9 with Frame_Done
        send_row(0, 1'b0, 0, '{1, 5, 3, 2});
        send_row(0, 1'b1, 0, '{4, 0, 7, 9});
        idle(3);

        // Signed compares on the 2-wide instance
        send_row(1, 1'b0, 0, '{-3, -8, 0, 0});
        send_row(1, 1'b1, 0, '{-5, -2, 0, 0});
        send_row(1, 1'b0, 0, '{-32768, 32767, 0, 0});
        send_row(1, 1'b1, 0, '{-100, 5, 0, 0});
        idle(3);

        // Valid gaps of three cycles between pixels
        send_row(0, 1'b0, 3, '{1, 5, 3, 2});
        send_row(0, 1'b1, 3, '{4, 0, 7, 9});
        idle(2);

        // Two back-to-back 4x4 frames
        rand_frame(2, 0);
        rand_frame(2, 0);
        idle(3);

        // Row parity flips at column 1, then a clean frame keeps the flag
        drive(0, 1'b1, 16'sd10, 1'b0);
        drive(0, 1'b1, 16'sd20, 1'b1);
        drive(0, 1'b1, -16'sd7, 1'b1);
        drive(0, 1'b1, 16'sd3,  1'b1);
        send_row(0, 1'b1, 0, '{2, 8, -1, 6});
        idle(2);
        rand_frame(0, 1);
        idle(2);
        do_reset();
        idle(2);

        // Reset after row 1 px2, then a fresh frame
        send_row(0, 1'b0, 0, '{1, 5, 3, 2});
        drive(0, 1'b1, 16'sd4, 1'b1);
        drive(0, 1'b1, 16'sd0, 1'b1);
        drive(0, 1'b1, 16'sd7, 1'b1);
        do_reset();
        idle(2);
        send_row(0, 1'b0, 0, '{1, 5, 3, 2});
        send_row(0, 1'b1, 0, '{4, 0, 7, 9});
        idle(3);

        // Randomized frames on every instance
        for (int n = 0; n < 4; n++) begin
            rand_frame(0, 2);
            rand_frame(1, 2);
            rand_frame(2, 1);
        end
        idle(5);

        chk("queue_drained", 0, q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
